// File: rtl/stalled_single_store_axil_master_pkg.sv
// Shared types and constants for the one-shot AXI4-Lite load/stall/store kernel.
package stalled_single_store_axil_master_pkg;

    typedef enum logic [2:0] {
        RD_ADDR,
        RD_DATA,
        STALL,
        WR,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/stalled_single_store_axil_master.sv
// One-shot AXI4-Lite master: load a word, idle for a fixed stall,
// store twice the word, then hold valid until reset.
module stalled_single_store_axil_master
    import stalled_single_store_axil_master_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    STRB_WIDTH   = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_ADDR    = 5'h04,
    parameter logic [ADDR_WIDTH-1:0] STORE_ADDR   = 5'h00,
    parameter int                    STALL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    output logic [2:0]            s_axil_awprot,
    output logic                  s_axil_awvalid,
    input  logic                  s_axil_awready,
    output logic [DATA_WIDTH-1:0] s_axil_wdata,
    output logic [STRB_WIDTH-1:0] s_axil_wstrb,
    output logic                  s_axil_wvalid,
    input  logic                  s_axil_wready,
    input  logic [1:0]            s_axil_bresp,
    input  logic                  s_axil_bvalid,
    output logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] s_axil_araddr,
    output logic [2:0]            s_axil_arprot,
    output logic                  s_axil_arvalid,
    input  logic                  s_axil_arready,
    input  logic [DATA_WIDTH-1:0] s_axil_rdata,
    input  logic [1:0]            s_axil_rresp,
    input  logic                  s_axil_rvalid,
    output logic                  s_axil_rready
);

    localparam int CNT_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] ld_reg;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  aw_clear;
    logic                  w_clear;

    // Error responses are deliberately treated as OKAY.
    logic unused_resp;
    assign unused_resp = ^{s_axil_rresp, s_axil_bresp};

    assign s_axil_araddr = LOAD_ADDR;
    assign s_axil_awaddr = STORE_ADDR;
    assign s_axil_arprot = PROT_DEFAULT;
    assign s_axil_awprot = PROT_DEFAULT;
    assign s_axil_wstrb  = '1;

    assign aw_fire  = s_axil_awvalid & s_axil_awready;
    assign w_fire   = s_axil_wvalid & s_axil_wready;
    assign aw_clear = ~s_axil_awvalid | s_axil_awready;
    assign w_clear  = ~s_axil_wvalid | s_axil_wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RD_ADDR;
            valid          <= 1'b0;
            s_axil_arvalid <= 1'b0;
            s_axil_rready  <= 1'b0;
            s_axil_awvalid <= 1'b0;
            s_axil_wvalid  <= 1'b0;
            s_axil_bready  <= 1'b0;
            s_axil_wdata   <= '0;
            ld_reg         <= '0;
            cnt            <= '0;
        end else begin
            unique case (state)
                RD_ADDR: begin
                    if (s_axil_arvalid && s_axil_arready) begin
                        s_axil_arvalid <= 1'b0;
                        s_axil_rready  <= 1'b1;
                        state          <= RD_DATA;
                    end else begin
                        s_axil_arvalid <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (s_axil_rready && s_axil_rvalid) begin
                        s_axil_rready <= 1'b0;
                        ld_reg        <= s_axil_rdata;
                        cnt           <= '0;
                        state         <= STALL;
                    end
                end
                STALL: begin
                    if (cnt == CNT_LAST) begin
                        s_axil_awvalid <= 1'b1;
                        s_axil_wvalid  <= 1'b1;
                        s_axil_wdata   <= ld_reg + ld_reg;
                        state          <= WR;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WR: begin
                    // AW and W retire independently; move on once both are gone.
                    if (aw_fire) s_axil_awvalid <= 1'b0;
                    if (w_fire) s_axil_wvalid <= 1'b0;
                    if (aw_clear && w_clear) begin
                        s_axil_bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axil_bvalid) begin
                        s_axil_bready <= 1'b0;
                        valid         <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b1;
                end
                default: begin
                    state <= RD_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stalled_single_store_axil_master.sv
// Bench: a reactive AXI4-Lite RAM model with configurable ready delays
// and a reference model of the load/stall/store kernel.
module tb_stalled_single_store_axil_master;

    localparam int         AW    = 5;
    localparam int         DW    = 32;
    localparam int         SW    = 4;
    localparam logic [4:0] LA    = 5'h04;
    localparam logic [4:0] SA    = 5'h00;
    localparam int         STALL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [DW-1:0] s_axil_wdata;
    logic [SW-1:0] s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;

    always #5 clk = ~clk;

    stalled_single_store_axil_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
        .LOAD_ADDR(LA), .STORE_ADDR(SA), .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
    );

    logic [31:0] mem [8];
    int          ar_dly, aw_dly, w_dly;
    bit          pre_rdy;
    int          cyc, ar_w, aw_w, w_w;
    int          ar_cnt, aw_cnt, w_cnt, b_cnt;
    int          proto_err, stab_err, post_err;
    int          r_edge, aw_edge;
    bit          aw_got, w_got;
    logic [4:0]  aw_a;
    logic [31:0] w_d;
    bit          pend_ar, pend_aw, pend_w;
    logic [4:0]  prev_araddr, prev_awaddr;
    logic [31:0] prev_wdata;
    int          total = 0;
    int          pass = 0;

    // RAM slave: ready rises after a programmable number of valid cycles
    // (or sits high from reset), responses one cycle after the handshake.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axil_arready <= pre_rdy;
            s_axil_awready <= pre_rdy;
            s_axil_wready  <= pre_rdy;
            s_axil_rvalid  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= 2'b00;
            s_axil_bresp   <= 2'b00;
            cyc = 0; ar_w = 0; aw_w = 0; w_w = 0;
            aw_got = 0; w_got = 0;
            pend_ar = 0; pend_aw = 0; pend_w = 0;
        end else begin
            cyc++;
            if (pend_ar && (!s_axil_arvalid || s_axil_araddr !== prev_araddr)) stab_err++;
            if (pend_aw && (!s_axil_awvalid || s_axil_awaddr !== prev_awaddr)) stab_err++;
            if (pend_w && (!s_axil_wvalid || s_axil_wdata !== prev_wdata)) stab_err++;
            pend_ar = s_axil_arvalid && !s_axil_arready;
            pend_aw = s_axil_awvalid && !s_axil_awready;
            pend_w  = s_axil_wvalid && !s_axil_wready;
            prev_araddr = s_axil_araddr;
            prev_awaddr = s_axil_awaddr;
            prev_wdata  = s_axil_wdata;
            if (valid && (s_axil_arvalid || s_axil_awvalid || s_axil_wvalid)) post_err++;
            if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
                r_edge = cyc;
            end
            if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
                b_cnt++;
            end
            if (s_axil_arvalid && s_axil_arready) begin
                ar_cnt++;
                if (s_axil_araddr !== LA || s_axil_arprot !== 3'b000) proto_err++;
                s_axil_rdata  <= mem[s_axil_araddr[4:2]];
                s_axil_rresp  <= 2'($urandom);
                s_axil_rvalid <= 1'b1;
                ar_w = 0;
                if (!pre_rdy) s_axil_arready <= 1'b0;
            end else if (s_axil_arvalid) begin
                if (ar_w >= ar_dly) s_axil_arready <= 1'b1;
                ar_w++;
            end
            if (s_axil_awvalid && aw_edge < 0) aw_edge = cyc;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_cnt++;
                if (s_axil_awprot !== 3'b000) proto_err++;
                aw_got = 1;
                aw_a = s_axil_awaddr;
                aw_w = 0;
                if (!pre_rdy) s_axil_awready <= 1'b0;
            end else if (s_axil_awvalid) begin
                if (aw_w >= aw_dly) s_axil_awready <= 1'b1;
                aw_w++;
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_cnt++;
                if (s_axil_wstrb !== 4'hF) proto_err++;
                w_got = 1;
                w_d = s_axil_wdata;
                w_w = 0;
                if (!pre_rdy) s_axil_wready <= 1'b0;
            end else if (s_axil_wvalid) begin
                if (w_w >= w_dly) s_axil_wready <= 1'b1;
                w_w++;
            end
            if (aw_got && w_got) begin
                mem[aw_a[4:2]] = w_d;
                aw_got = 0;
                w_got = 0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= 2'($urandom);
            end
        end
    end

    task automatic release_rst();
        rst = 1'b0;
        @(negedge clk);
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        proto_err = 0; stab_err = 0; post_err = 0;
        r_edge = -1; aw_edge = -1;
        rst = 1'b1;
    endtask

    task automatic run(output bit to);
        release_rst();
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Reference: the store is the loaded word doubled, carry dropped.
    function automatic logic [31:0] model_store(input logic [31:0] w);
        logic [32:0] s;
        s = {1'b0, w} + {1'b0, w};
        return s[31:0];
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({valid, s_axil_arvalid, s_axil_rready, s_axil_awvalid, s_axil_wvalid, s_axil_bready} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                {valid, s_axil_arvalid, s_axil_rready, s_axil_awvalid, s_axil_wvalid, s_axil_bready});
        else pass++;
        total++;
        if (s_axil_wdata !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", s_axil_wdata);
        else pass++;
    endtask

    task automatic test_basic();
        bit seen;
        ar_dly = 0; aw_dly = 0; w_dly = 0; pre_rdy = 0;
        mem[1] = 32'd10; mem[0] = 32'hDEAD_BEEF;
        release_rst();
        seen = 0;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk);
            #1;
            if (e == 4 || e == 8 || e == 9) begin
                total++;
                if (valid !== 1'b0) $display("FAIL basic_early_e%0d: got %b expected 0", e, valid);
                else pass++;
            end
            if (valid === 1'b1) seen = 1;
        end
        total++;
        if (!seen) $display("FAIL basic_by19: got 0 expected 1");
        else pass++;
        total++;
        if (mem[0] !== 32'd20) $display("FAIL basic_word0: got %0d expected 20", mem[0]);
        else pass++;
        total++;
        if ({ar_cnt, aw_cnt, w_cnt, b_cnt} !== {32'd1, 32'd1, 32'd1, 32'd1})
            $display("FAIL basic_xfers: got ar%0d aw%0d w%0d b%0d expected 1 each", ar_cnt, aw_cnt, w_cnt, b_cnt);
        else pass++;
        total++;
        if (aw_edge - r_edge !== STALL + 1)
            $display("FAIL basic_stall_gap: got %0d expected %0d", aw_edge - r_edge, STALL + 1);
        else pass++;
        total++;
        if (proto_err + stab_err !== 0)
            $display("FAIL basic_proto: got %0d errors expected 0", proto_err + stab_err);
        else pass++;
    endtask

    task automatic test_value(input string nm, input logic [31:0] w, input logic [31:0] req);
        bit to;
        ar_dly = 1; aw_dly = 0; w_dly = 1; pre_rdy = 0;
        mem[1] = w; mem[0] = 32'h1234_5678;
        run(to);
        total++;
        if (to) $display("FAIL %s_timeout: got valid 0 expected 1", nm);
        else pass++;
        total++;
        if (mem[0] !== req) $display("FAIL %s_word0: got %h expected %h", nm, mem[0], req);
        else pass++;
        total++;
        if (mem[1] !== w) $display("FAIL %s_word1: got %h expected %h", nm, mem[1], w);
        else pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        ar_dly = 5; aw_dly = 5; w_dly = 2; pre_rdy = 0;
        mem[1] = 32'd21; mem[0] = 32'h0;
        run(to);
        total++;
        if (to || mem[0] !== model_store(32'd21))
            $display("FAIL bp_word0: got %h (to=%0d) expected %h", mem[0], to, model_store(32'd21));
        else pass++;
        total++;
        if (stab_err !== 0) $display("FAIL bp_stable: got %0d errors expected 0", stab_err);
        else pass++;
        total++;
        if ({ar_cnt, aw_cnt, w_cnt} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL bp_xfers: got ar%0d aw%0d w%0d expected 1 each", ar_cnt, aw_cnt, w_cnt);
        else pass++;
        total++;
        if (aw_edge - r_edge !== STALL + 1)
            $display("FAIL bp_stall_gap: got %0d expected %0d", aw_edge - r_edge, STALL + 1);
        else pass++;
    endtask

    task automatic test_random();
        bit          to;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            ar_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            pre_rdy = 1'($urandom);
            w = $urandom;
            mem[1] = w; mem[0] = ~w;
            run(to);
            total++;
            if (to || mem[0] !== model_store(w))
                $display("FAIL rand%0d_word0: got %h (to=%0d) expected %h", i, mem[0], to, model_store(w));
            else pass++;
            total++;
            if ({ar_cnt, aw_cnt, w_cnt, stab_err, proto_err} !== {32'd1, 32'd1, 32'd1, 32'd0, 32'd0})
                $display("FAIL rand%0d_xfers: got ar%0d aw%0d w%0d stab%0d proto%0d expected 1/1/1/0/0",
                    i, ar_cnt, aw_cnt, w_cnt, stab_err, proto_err);
            else pass++;
            total++;
            if (aw_edge - r_edge !== STALL + 1)
                $display("FAIL rand%0d_stall_gap: got %0d expected %0d", i, aw_edge - r_edge, STALL + 1);
            else pass++;
        end
    endtask

    task automatic test_reset_stall();
        bit to;
        bit hit;
        ar_dly = 0; aw_dly = 0; w_dly = 0; pre_rdy = 0;
        mem[1] = 32'd10; mem[0] = 32'hCAFE_F00D;
        release_rst();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (r_edge >= 0) hit = 1;
        end
        total++;
        if (!hit) $display("FAIL rst_stall_reach: got no R handshake expected one");
        else pass++;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({valid, s_axil_arvalid, s_axil_rready, s_axil_awvalid, s_axil_wvalid, s_axil_bready} !== 6'b0
            || s_axil_wdata !== 32'h0)
            $display("FAIL rst_stall_outputs: got %b/%h expected 000000/0",
                {valid, s_axil_arvalid, s_axil_rready, s_axil_awvalid, s_axil_wvalid, s_axil_bready},
                s_axil_wdata);
        else pass++;
        total++;
        if (mem[0] !== 32'hCAFE_F00D) $display("FAIL rst_stall_nowrite: got %h expected cafef00d", mem[0]);
        else pass++;
        run(to);
        total++;
        if (to || mem[0] !== 32'd20) $display("FAIL rst_rerun_word0: got %0d (to=%0d) expected 20", mem[0], to);
        else pass++;
        total++;
        if ({ar_cnt, aw_cnt, w_cnt} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL rst_rerun_xfers: got ar%0d aw%0d w%0d expected 1 each", ar_cnt, aw_cnt, w_cnt);
        else pass++;
    endtask

    task automatic test_done_hold();
        int drops;
        int ar0;
        drops = 0;
        ar0 = ar_cnt;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b1) drops++;
        end
        total++;
        if (drops !== 0) $display("FAIL hold_valid: got %0d low cycles expected 0", drops);
        else pass++;
        total++;
        if (post_err !== 0 || ar_cnt !== ar0)
            $display("FAIL hold_quiet: got %0d busy cycles, ar %0d expected 0, %0d", post_err, ar_cnt, ar0);
        else pass++;
    endtask

    initial begin
        ar_dly = 0; aw_dly = 0; w_dly = 0; pre_rdy = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_value("carry", 32'h8000_0000, 32'h0000_0000);
        test_value("max", 32'h7FFF_FFFF, 32'hFFFF_FFFE);
        test_backpressure();
        test_random();
        test_reset_stall();
        test_done_hold();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
